// File: rtl/abm_responder.sv
// AXI4 slave RAM model for the ABM/PCI data movers. INCR/FIXED write bursts go into an
// internal DEPTH x DW word RAM; read bursts are served back through a 2-entry prefetch buffer.
module abm_responder #(
  parameter int DW    = 512,
  parameter int AW    = 64,
  parameter int DEPTH = 16384
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   S_AXI_AWADDR,
  input  logic [7:0]      S_AXI_AWLEN,
  input  logic [2:0]      S_AXI_AWSIZE,
  input  logic [1:0]      S_AXI_AWBURST,
  input  logic [3:0]      S_AXI_AWID,
  input  logic            S_AXI_AWVALID,
  output logic            S_AXI_AWREADY,
  input  logic [DW-1:0]   S_AXI_WDATA,
  input  logic [DW/8-1:0] S_AXI_WSTRB,
  input  logic            S_AXI_WLAST,
  input  logic            S_AXI_WVALID,
  output logic            S_AXI_WREADY,
  output logic [1:0]      S_AXI_BRESP,
  output logic [3:0]      S_AXI_BID,
  output logic            S_AXI_BVALID,
  input  logic            S_AXI_BREADY,
  input  logic [AW-1:0]   S_AXI_ARADDR,
  input  logic [7:0]      S_AXI_ARLEN,
  input  logic [2:0]      S_AXI_ARSIZE,
  input  logic [1:0]      S_AXI_ARBURST,
  input  logic [3:0]      S_AXI_ARID,
  input  logic            S_AXI_ARVALID,
  output logic            S_AXI_ARREADY,
  output logic [DW-1:0]   S_AXI_RDATA,
  output logic [1:0]      S_AXI_RRESP,
  output logic            S_AXI_RLAST,
  output logic [3:0]      S_AXI_RID,
  output logic            S_AXI_RVALID,
  input  logic            S_AXI_RREADY,
  output logic [1:0]      dbg_w_state_o,
  output logic [1:0]      dbg_r_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the source holds its payload stable while valid is high and ready is low.
  localparam int SW  = DW / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(OFF);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_STREAM = 2'd1} r_state_t;

  logic [DW-1:0] mem [DEPTH];

  w_state_t      w_state_q, w_state_d;
  logic          awready_q;
  logic [IW-1:0] w_idx_q, w_idx_d;
  logic [7:0]    w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic          w_fixed_q, w_fixed_d, w_err_q, w_err_d;
  logic [3:0]    w_id_q, w_id_d;
  logic          aw_hs, w_hs, w_end;

  r_state_t      r_state_q, r_state_d;
  logic          arready_q;
  logic [IW-1:0] r_idx_q, r_idx_d;
  logic [7:0]    r_len_q, r_len_d;
  logic [8:0]    r_iss_q, r_iss_d;
  logic          r_fixed_q, r_fixed_d, r_err_q, r_err_d;
  logic [3:0]    r_id_q, r_id_d;
  logic          ar_hs, r_valid, r_pop, r_push;

  // Prefetch buffer: the RAM read lands directly in a slot, so data is registered once.
  logic [DW-1:0] q_data [2];
  logic [1:0]    q_last_q;
  logic [1:0]    q_cnt_q;
  logic          q_wp_q, q_rp_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && (w_state_q == W_DATA);
  assign w_end = w_hs && (S_AXI_WLAST || (w_cnt_q == w_len_q));

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    w_id_d    = w_id_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_state_d = W_DATA;
        w_idx_d   = S_AXI_AWADDR[OFF +: IW];
        w_len_d   = S_AXI_AWLEN;
        w_cnt_d   = 8'd0;
        w_fixed_d = (S_AXI_AWBURST == 2'b00);
        w_err_d   = S_AXI_AWBURST[1] || (S_AXI_AWSIZE != FULL_SIZE);
        w_id_d    = S_AXI_AWID;
      end
      W_DATA: if (w_hs) begin
        w_cnt_d = w_cnt_q + 8'd1;
        if (!w_fixed_q) w_idx_d = w_idx_q + IW'(1);
        if (S_AXI_WLAST != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
        if (w_end) w_state_d = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign ar_hs   = S_AXI_ARVALID && arready_q;
  assign r_valid = (q_cnt_q != 2'd0);
  assign r_pop   = r_valid && S_AXI_RREADY;
  assign r_push  = (r_state_q == R_STREAM) && (r_iss_q <= {1'b0, r_len_q}) &&
                   ((q_cnt_q < 2'd2) || r_pop);

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_iss_d   = r_iss_q;
    r_fixed_d = r_fixed_q;
    r_err_d   = r_err_q;
    r_id_d    = r_id_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_STREAM;
        r_idx_d   = S_AXI_ARADDR[OFF +: IW];
        r_len_d   = S_AXI_ARLEN;
        r_iss_d   = 9'd0;
        r_fixed_d = (S_AXI_ARBURST == 2'b00);
        r_err_d   = S_AXI_ARBURST[1] || (S_AXI_ARSIZE != FULL_SIZE);
        r_id_d    = S_AXI_ARID;
      end
      R_STREAM: begin
        if (r_push) begin
          r_iss_d = r_iss_q + 9'd1;
          if (!r_fixed_q) r_idx_d = r_idx_q + IW'(1);
        end
        if (r_pop && q_last_q[q_rp_q]) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      w_id_q    <= 4'd0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      r_idx_q   <= '0;
      r_len_q   <= 8'd0;
      r_iss_q   <= 9'd0;
      r_fixed_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_id_q    <= 4'd0;
      q_last_q  <= 2'b00;
      q_cnt_q   <= 2'd0;
      q_wp_q    <= 1'b0;
      q_rp_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE);
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      w_id_q    <= w_id_d;
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_iss_q   <= r_iss_d;
      r_fixed_q <= r_fixed_d;
      r_err_q   <= r_err_d;
      r_id_q    <= r_id_d;
      if (r_push) begin
        q_last_q[q_wp_q] <= (r_iss_q[7:0] == r_len_q);
        q_wp_q           <= ~q_wp_q;
      end
      if (r_pop) q_rp_q <= ~q_rp_q;
      q_cnt_q <= q_cnt_q + {1'b0, r_push} - {1'b0, r_pop};
    end
  end

  // Read-first on a same-word collision: the slot load sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < SW; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx_q][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
    if (r_push) q_data[q_wp_q] <= mem[r_idx_q];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = (w_state_q == W_DATA);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = S_AXI_BVALID ? {w_err_q, 1'b0} : 2'b00;
  assign S_AXI_BID     = S_AXI_BVALID ? w_id_q : 4'd0;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_valid ? q_data[q_rp_q] : '0;
  assign S_AXI_RLAST   = r_valid && q_last_q[q_rp_q];
  assign S_AXI_RRESP   = r_valid ? {r_err_q, 1'b0} : 2'b00;
  assign S_AXI_RID     = r_valid ? r_id_q : 4'd0;
  assign dbg_w_state_o = w_state_q;
  assign dbg_r_state_o = r_state_q;
endmodule

// File: tb/tb_abm_responder.sv
// Bench for abm_responder: directed bursts against a word-array memory model, with a
// scoreboard that checks every R and B beat plus handshake timing and reset behaviour.
module tb_abm_responder;
  localparam int DW    = 512;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16384;
  localparam int RW    = DW + 7;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [63:0]     S_AXI_AWADDR = '0;
  logic [7:0]      S_AXI_AWLEN = '0;
  logic [2:0]      S_AXI_AWSIZE = '0;
  logic [1:0]      S_AXI_AWBURST = '0;
  logic [3:0]      S_AXI_AWID = '0;
  logic            S_AXI_AWVALID = 1'b0;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA = '0;
  logic [SW-1:0]   S_AXI_WSTRB = '0;
  logic            S_AXI_WLAST = 1'b0;
  logic            S_AXI_WVALID = 1'b0;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic [3:0]      S_AXI_BID;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY = 1'b1;
  logic [63:0]     S_AXI_ARADDR = '0;
  logic [7:0]      S_AXI_ARLEN = '0;
  logic [2:0]      S_AXI_ARSIZE = '0;
  logic [1:0]      S_AXI_ARBURST = '0;
  logic [3:0]      S_AXI_ARID = '0;
  logic            S_AXI_ARVALID = 1'b0;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RLAST;
  logic [3:0]      S_AXI_RID;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY = 1'b1;
  logic [1:0]      dbg_w_state;
  logic [1:0]      dbg_r_state;

  abm_responder #(.DW(DW), .AW(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BID(S_AXI_BID), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .dbg_w_state_o(dbg_w_state), .dbg_r_state_o(dbg_r_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  logic [DW-1:0] model_mem [int];
  logic [RW-1:0] exp_q [$];
  logic [5:0]    exp_b_q [$];
  logic [DW-1:0] wd_buf [256];
  logic [SW-1:0] ws_buf [256];
  int            n_checks = 0;
  int            n_errors = 0;
  int            r_popped = 0;
  logic [3:0]    last_bid = '0, last_rid = '0;
  logic [1:0]    last_bresp = '0, last_rresp = '0;
  bit            rr_random = 1'b0;

  task automatic check(input string name, input logic [599:0] act, input logic [599:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RREADY pattern: held high, or pseudo-random for backpressure.
  initial forever begin
    @(posedge clk); #1;
    S_AXI_RREADY = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every R/B handshake against the expected queues, plus R stability.
  initial begin
    logic          stall_prev;
    logic [RW-1:0] prev_r, cur_r, e;
    logic [5:0]    eb;
    stall_prev = 1'b0;
    prev_r = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        cur_r = {S_AXI_RLAST, S_AXI_RRESP, S_AXI_RID, S_AXI_RDATA};
        if (stall_prev) check("r_stable", {S_AXI_RVALID, cur_r}, {1'b1, prev_r});
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL r_extra_beat: got beat %0h, expected no beat", cur_r);
          end else begin
            e = exp_q.pop_front();
            n_checks--;
            check("r_beat", cur_r, e);
            r_popped++;
            last_rid = S_AXI_RID;
            last_rresp = S_AXI_RRESP;
          end
        end
        stall_prev = S_AXI_RVALID && !S_AXI_RREADY;
        prev_r = cur_r;
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          if (exp_b_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL b_extra: got resp %0h id %0h, expected no response", S_AXI_BRESP, S_AXI_BID);
          end else begin
            eb = exp_b_q.pop_front();
            check("b_resp", {S_AXI_BRESP, S_AXI_BID}, eb);
            last_bid = S_AXI_BID;
            last_bresp = S_AXI_BRESP;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_pattern(input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 16; j++) wd_buf[i][j*32 +: 32] = seed + 32'(i * 16 + j);
      ws_buf[i] = '1;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID,
                           S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RID}, '0);
    check({name, "_rdata"}, S_AXI_RDATA, '0);
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    #1 check("rel_ready_low", {S_AXI_AWREADY, S_AXI_ARREADY}, 2'b00);
    @(negedge clk);
    check("idle_ready_high", {S_AXI_AWREADY, S_AXI_ARREADY}, 2'b11);
  endtask

  // last_at: beat index carrying WLAST (-1 = never). The slave ends at len or WLAST.
  task automatic write_burst(input logic [63:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id, input int last_at);
    int base, nb, t, idx;
    bit err;
    base = int'((addr >> 6) % DEPTH);
    nb   = (last_at >= 0 && last_at < len) ? last_at + 1 : len + 1;
    err  = burst[1] || (size != 3'd6) || (last_at != len);
    exp_b_q.push_back({(err ? 2'b10 : 2'b00), id});
    @(posedge clk); #1;
    S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWBURST = burst;
    S_AXI_AWSIZE = size; S_AXI_AWID = id; S_AXI_AWVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!S_AXI_AWREADY && t < 50);
    check("aw_ready", S_AXI_AWREADY, 1'b1);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < nb; i++) begin
      S_AXI_WVALID = 1'b1; S_AXI_WDATA = wd_buf[i]; S_AXI_WSTRB = ws_buf[i];
      S_AXI_WLAST = (i == last_at);
      @(negedge clk);
      if (i == 0) begin
        check("aw_drop", S_AXI_AWREADY, 1'b0);
        check("w_first_ready", S_AXI_WREADY, 1'b1);
      end
      t = 0;
      while (!S_AXI_WREADY && t < 20) begin @(negedge clk); t++; end
      check("w_ready", S_AXI_WREADY, 1'b1);
      @(posedge clk); #1;
      idx = (burst == FIXED) ? base : (base + i) % DEPTH;
      for (int b = 0; b < SW; b++)
        if (ws_buf[i][b]) model_mem[idx][b*8 +: 8] = wd_buf[i][b*8 +: 8];
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    @(negedge clk);
    check("b_timing", {S_AXI_BVALID, S_AXI_WREADY}, 2'b10);
    t = 0;
    while (exp_b_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
    check("b_done", 32'(exp_b_q.size()), 32'd0);
    exp_b_q.delete();
  endtask

  task automatic push_read_exp(input logic [63:0] addr, input int len, input logic [1:0] burst,
                               input logic [2:0] size, input logic [3:0] id);
    int base, idx;
    logic [1:0] resp;
    base = int'((addr >> 6) % DEPTH);
    resp = (burst[1] || size != 3'd6) ? 2'b10 : 2'b00;
    for (int i = 0; i <= len; i++) begin
      idx = (burst == FIXED) ? base : (base + i) % DEPTH;
      exp_q.push_back({(i == len), resp, id, model_mem[idx]});
    end
  endtask

  task automatic issue_ar(input logic [63:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id);
    int t;
    @(posedge clk); #1;
    S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARBURST = burst;
    S_AXI_ARSIZE = size; S_AXI_ARID = id; S_AXI_ARVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!S_AXI_ARREADY && t < 50);
    check("ar_ready", S_AXI_ARREADY, 1'b1);
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("ar_drop_rlat1", {S_AXI_ARREADY, S_AXI_RVALID}, 2'b00);
    @(negedge clk);
    check("r_lat2", S_AXI_RVALID, 1'b1);
  endtask

  task automatic read_burst(input logic [63:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id);
    int t;
    push_read_exp(addr, len, burst, size, id);
    issue_ar(addr, len, burst, size, id);
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    check("r_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  function automatic logic [63:0] waddr(input int w);
    return 64'(w) << 6;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    release_reset();

    // Write 256 beats then read them back.
    fill_pattern(256, 32'h1000_0000);
    write_burst(waddr(0), 255, INCR, 3'd6, 4'd1, 255);
    check("bresp_ok", last_bresp, 2'b00);
    read_burst(waddr(0), 255, INCR, 3'd6, 4'd2);
    check("rresp_ok", last_rresp, 2'b00);

    // Byte strobes on word 3.
    wd_buf[0] = '1; ws_buf[0] = '1;
    write_burst(waddr(3), 0, INCR, 3'd6, 4'd1, 0);
    wd_buf[0] = '0; ws_buf[0] = 64'h0000_0000_0000_000F;
    write_burst(waddr(3), 0, INCR, 3'd6, 4'd1, 0);
    check("pin_strobe", model_mem[3], {{60{8'hFF}}, 32'h0});
    read_burst(waddr(3), 0, INCR, 3'd6, 4'd3);

    // Backpressure on a 16-beat read.
    rr_random = 1'b1;
    read_burst(waddr(16), 15, INCR, 3'd6, 4'd3);
    rr_random = 1'b0;

    // INCR wrap at the top of the RAM, FIXED overwrite, high/unaligned address.
    for (int k = 0; k < 4; k++) begin wd_buf[k] = {16{32'hC0DE_0000 + 32'(k)}}; ws_buf[k] = '1; end
    write_burst(waddr(DEPTH - 2), 3, INCR, 3'd6, 4'd4, 3);
    check("pin_wrap_top", model_mem[DEPTH-2], {16{32'hC0DE_0000}});
    check("pin_wrap_end", model_mem[DEPTH-1], {16{32'hC0DE_0001}});
    check("pin_wrap_zero", model_mem[0], {16{32'hC0DE_0002}});
    check("pin_wrap_one", model_mem[1], {16{32'hC0DE_0003}});
    read_burst(waddr(DEPTH - 2), 3, INCR, 3'd6, 4'd4);
    for (int k = 0; k < 4; k++) wd_buf[k] = {16{32'hF1C0_0000 + 32'(k)}};
    write_burst(waddr(40), 3, FIXED, 3'd6, 4'd4, 3);
    check("pin_fixed", model_mem[40], {16{32'hF1C0_0003}});
    check("pin_fixed_next", model_mem[41], {16{32'h1000_0000 + 32'(41 * 16)}} & {16{32'hFFFF_FF00}} |
          {16{32'h0}} | model_mem[41] & {16{32'h0000_00FF}});
    read_burst(waddr(40), 2, FIXED, 3'd6, 4'd4);
    fill_pattern(1, 32'h6600_0000);
    write_burst(waddr(DEPTH + 100) + 64'd13, 0, INCR, 3'd6, 4'd6, 0);
    check("pin_high_addr", model_mem[100][31:0], 32'h6600_0000);
    read_burst(waddr(100), 0, INCR, 3'd6, 4'd6);

    // Protocol errors.
    fill_pattern(8, 32'h2200_0000);
    write_burst(waddr(200), 7, INCR, 3'd6, 4'd5, 2);
    check("bid_echo", last_bid, 4'd5);
    check("bresp_early_wlast", last_bresp, 2'b10);
    read_burst(waddr(200), 2, INCR, 3'd6, 4'd8);
    write_burst(waddr(210), 1, INCR, 3'd6, 4'd2, -1);
    check("bresp_no_wlast", last_bresp, 2'b10);
    write_burst(waddr(220), 1, RSVD, 3'd5, 4'd3, 1);
    check("bresp_rsvd_size", last_bresp, 2'b10);
    read_burst(waddr(0), 3, INCR, 3'b010, 4'd9);
    check("rid_echo", last_rid, 4'd9);
    check("rresp_size", last_rresp, 2'b10);
    read_burst(waddr(DEPTH - 1), 3, WRAP, 3'd6, 4'd7);
    check("rresp_wrap", last_rresp, 2'b10);

    // Reset during beat 5 of a 64-beat read.
    r_popped = 0;
    push_read_exp(waddr(0), 63, INCR, 3'd6, 4'hA);
    issue_ar(waddr(0), 63, INCR, 3'd6, 4'hA);
    t = 0;
    while (r_popped < 4 && t < 100) begin @(negedge clk); #1; t++; end
    check("rst_beats_before", 32'(r_popped), 32'd4);
    @(negedge clk); #1;
    check("rst_beat5_valid", S_AXI_RVALID, 1'b1);
    reset = 1'b1;
    #1 check_reset_outputs("reset_mid_read");
    exp_q.delete();
    exp_b_q.delete();
    repeat (3) @(negedge clk);
    check("reset_hold_rvalid", S_AXI_RVALID, 1'b0);
    release_reset();
    read_burst(waddr(0), 7, INCR, 3'd6, 4'hB);
    fill_pattern(2, 32'h7700_0000);
    write_burst(waddr(500), 1, INCR, 3'd6, 4'd1, 1);
    read_burst(waddr(500), 1, INCR, 3'd6, 4'd1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got no completion by %0t, expected sequence to finish", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/abm_responder.md
# abm_responder

AXI4 slave that answers the burst traffic issued by the ABM/PCI data-mover masters. It holds an internal word-addressed RAM of DEPTH x DW bits, accepts INCR/FIXED write bursts into it, and serves read bursts from it. Read and write channels run independently. It sits on the slave side of a mover as the source memory model or scratch buffer, for both bench use and on-chip loopback.

## Interface
- DW, 512, data width in bits; power of two, at least 32.
- AW, 64, address width in bits.
- DEPTH, 16384, RAM depth in DW-bit words; power of two.
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset; one clock, reset asynchronous active-high.
- S_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWID/AWVALID  in  AW/8/3/2/4/1  write address channel.
- S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WLAST/WVALID  in  DW/DW÷8/1/1  write data channel.
- S_AXI_WREADY  out  1.
- S_AXI_BRESP/BID/BVALID  out  2/4/1; S_AXI_BREADY  in  1  write response channel.
- S_AXI_ARADDR/ARLEN/ARSIZE/ARBURST/ARID/ARVALID  in  AW/8/3/2/4/1  read address channel.
- S_AXI_ARREADY  out  1.
- S_AXI_RDATA/RRESP/RLAST/RID/RVALID  out  DW/2/1/4/1; S_AXI_RREADY  in  1  read data channel.
- AWLOCK/AWCACHE/AWQOS/AWPROT and the AR equivalents are not ports; the master ties them off.

## Operation
- Word index = (addr >> log2(DW/8)) mod DEPTH. Low address bits are ignored, so unaligned addresses round down. Addresses above the RAM size wrap; no DECERR is generated.
- Burst length = AxLEN+1 beats.
- INCR: index += 1 per beat, wrapping mod DEPTH.
- FIXED: index is held.
- WRAP (2) and reserved (3): treated as INCR, with the response coded SLVERR (2'b10).
- AxSIZE != log2(DW/8): the transfer still completes at full width, with the response coded SLVERR.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch index, len, burst, ID and the error flag, then go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB; bytes with a 0 strobe are untouched.
  - The burst ends on the beat where the beat count reaches len or WLAST=1, whichever comes first.
  - If WLAST is not asserted exactly on beat len+1, set the error flag. Then go to W_RESP.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY (2'b00) or SLVERR. Hold until BREADY, then return to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, latch index, len, burst, ID and the error flag, then go to R_STREAM.
  - R_STREAM: beats are presented in order. RID=latched ID; RRESP=OKAY or SLVERR on every beat; RLAST=1 only on beat len+1.
  - After the RLAST handshake, return to R_IDLE.
- One outstanding burst per channel; there is no interleaving and no reordering.
- Read/write collision on the same word in the same cycle: the read returns the old data (read-first).
- RAM contents are not cleared by reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0. The FSMs enter IDLE on the first clock after reset deasserts.
- AWREADY and ARREADY are registered. They are high in IDLE and drop on the cycle after the handshake.
- The first W beat can be accepted on the cycle after the AW handshake.
- WREADY stays high for the whole of W_DATA; throughput is 1 beat/cycle.
- BVALID rises on the cycle after the final W beat.
- The next AW can be accepted on the cycle after the B handshake.
- The first RVALID appears 2 cycles after the AR handshake, reflecting one registered RAM read.
- With RREADY held high, throughput is 1 beat/cycle; the implementation needs a 2-entry skid/prefetch.
- While RVALID=1 and RREADY=0, RDATA/RLAST/RRESP/RID stay stable. Beats are never dropped or duplicated.
- Reset mid-burst: all outputs drop immediately to their reset values. The burst in progress is abandoned and no B or R beat is emitted for it.

## Test plan
- Write then read back: write 256-beat INCR at 0x0 with an incrementing pattern, then read 256 beats from 0x0. Required: identical data, RLAST only on beat 256, BRESP=0, RRESP=0.
- Byte strobes: first fill word 3 with 0xFF..FF using a full-strobe write, then write 0x00 to word 3 with WSTRB=0x...0F, then read word 3. Required: low 4 bytes 0x00, remaining bytes 0xFF.
- Backpressure: 16-beat read with RREADY toggled pseudo-randomly. Required: 16 beats in order, payload stable while stalled, first RVALID 2 cycles after the AR handshake.
- Address wrap with FIXED: an INCR 4-beat write starting at word DEPTH-2 lands in words DEPTH-2, DEPTH-1, 0, 1. A FIXED 4-beat write leaves only its last beat in the target word.
- Protocol errors: early WLAST on beat 3 of AWLEN=7 gives BRESP=2'b10 after beat 3. ARSIZE=3'b010 with DW=512 gives RRESP=2'b10 on all beats. BID and RID echo AWID=5 and ARID=9.
- Reset mid-read: assert reset during beat 5 of a 64-beat read. Required: RVALID=0 the same cycle. After release, a fresh read returns the data written before reset.
